// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline MEM stage (P) and a debug/DMA port (D), with D burst lock and forced release.
// Build option: define DMEM_ARB_RR_EN for round-robin contention; otherwise P has fixed priority.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int MAX_LOCK = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_p_req,
  input  logic          i_p_we,
  input  logic [31:0]   i_p_addr,
  input  logic [31:0]   i_p_wdata,
  output logic          o_p_gnt,
  output logic          o_p_stall,
  input  logic          i_d_req,
  input  logic          i_d_we,
  input  logic          i_d_lock,
  input  logic [31:0]   i_d_addr,
  input  logic [31:0]   i_d_wdata,
  output logic          o_d_gnt,
  output logic          o_p_rvalid,
  output logic          o_d_rvalid,
  output logic [31:0]   o_rdata,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wd,
  input  logic [31:0]   i_mem_rd
);

  localparam logic [7:0] LOCK_MAX = 8'(MAX_LOCK);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAST_P,
    S_LAST_D,
    S_LOCK_D
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_lock_cnt;
  logic [7:0] w_lock_cnt_nxt;
  logic       r_p_rvalid;
  logic       r_d_rvalid;
  logic       w_p_gnt;
  logic       w_d_gnt;
  logic       w_lock_hold;
  logic       w_lock_full;
  logic       w_unused_addr;

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: 1 when D was the most recent owner.
  logic r_last_d;
  logic w_last_d_nxt;
`endif

  assign w_lock_hold   = (r_state == S_LOCK_D) && i_d_req && i_d_lock;
  assign w_lock_full   = (r_lock_cnt >= LOCK_MAX);
  assign w_unused_addr = ^{i_p_addr[31:AW], i_d_addr[31:AW]};

  always_comb begin
    w_p_gnt        = 1'b0;
    w_d_gnt        = 1'b0;
    w_state_nxt    = S_IDLE;
    w_lock_cnt_nxt = 8'd0;
`ifdef DMEM_ARB_RR_EN
    w_last_d_nxt   = r_last_d;
`endif
    if (!i_rst) begin
      w_p_gnt = 1'b0;
    end else if (w_lock_hold) begin
      // A full lock only yields when P is actually waiting.
      if (w_lock_full && i_p_req) w_p_gnt = 1'b1;
      else                        w_d_gnt = 1'b1;
    end else if (i_p_req && i_d_req) begin
`ifdef DMEM_ARB_RR_EN
      if (r_last_d) w_p_gnt = 1'b1;
      else          w_d_gnt = 1'b1;
`else
      w_p_gnt = 1'b1;
`endif
    end else if (i_p_req) begin
      w_p_gnt = 1'b1;
    end else if (i_d_req) begin
      w_d_gnt = 1'b1;
    end

    if (w_p_gnt) begin
      w_state_nxt = S_LAST_P;
`ifdef DMEM_ARB_RR_EN
      w_last_d_nxt = 1'b0;
`endif
    end else if (w_d_gnt) begin
`ifdef DMEM_ARB_RR_EN
      w_last_d_nxt = 1'b1;
`endif
      if (i_d_lock) begin
        w_state_nxt = S_LOCK_D;
        if (!w_lock_hold)     w_lock_cnt_nxt = 8'd1;
        else if (w_lock_full) w_lock_cnt_nxt = r_lock_cnt;
        else                  w_lock_cnt_nxt = 8'(r_lock_cnt + 8'd1);
      end else begin
        w_state_nxt = S_LAST_D;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_lock_cnt <= 8'd0;
      r_p_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_p_rvalid <= w_p_gnt && !i_p_we;
      r_d_rvalid <= w_d_gnt && !i_d_we;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_last_d <= 1'b1;
    else        r_last_d <= w_last_d_nxt;
  end
`endif

  always_comb begin
    o_mem_we   = 1'b0;
    o_mem_addr = '0;
    o_mem_wd   = 32'd0;
    if (w_p_gnt) begin
      o_mem_we   = i_p_we;
      o_mem_addr = i_p_addr[AW-1:0];
      o_mem_wd   = i_p_wdata;
    end else if (w_d_gnt) begin
      o_mem_we   = i_d_we;
      o_mem_addr = i_d_addr[AW-1:0];
      o_mem_wd   = i_d_wdata;
    end
  end

  assign o_p_gnt    = w_p_gnt;
  assign o_d_gnt    = w_d_gnt;
  assign o_p_stall  = i_rst && i_p_req && !w_p_gnt;
  assign o_p_rvalid = r_p_rvalid;
  assign o_d_rvalid = r_d_rvalid;
  assign o_rdata    = i_rst ? i_mem_rd : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, lock/saturation/reset sequences, read-data scoreboard.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p_req = 0, p_we = 0, d_req = 0, d_we = 0, d_lock = 0;
  logic [31:0] p_addr = 0, p_wdata = 0, d_addr = 0, d_wdata = 0;
  logic        p_gnt, p_stall, d_gnt, p_rvalid, d_rvalid, mem_we;
  logic [31:0] rdata, mem_wd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rd;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          pr, pw;
    logic [31:0] pa, pd;
    bit          dr, dw, dl;
    logic [31:0] da, dd;
    bit          epg, edg;
  } vec_t;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } rd_t;

  rd_t sb[$];

  dmem_arbiter #(.AW(8), .MAX_LOCK(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_p_req(p_req), .i_p_we(p_we), .i_p_addr(p_addr), .i_p_wdata(p_wdata),
    .o_p_gnt(p_gnt), .o_p_stall(p_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_lock(d_lock), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_gnt(d_gnt), .o_p_rvalid(p_rvalid), .o_d_rvalid(d_rvalid), .o_rdata(rdata),
    .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
    mem_rd <= mem[mem_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit pr, bit pw, logic [31:0] pa, logic [31:0] pd,
                              bit dr, bit dw, bit dl, logic [31:0] da, logic [31:0] dd,
                              bit epg, bit edg);
    vec_t v;
    v.pr = pr; v.pw = pw; v.pa = pa; v.pd = pd;
    v.dr = dr; v.dw = dw; v.dl = dl; v.da = da; v.dd = dd;
    v.epg = epg; v.edg = edg;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic [7:0] ea;
    rd_t it;
    @(negedge clk);
    p_req = v.pr; p_we = v.pw; p_addr = v.pa; p_wdata = v.pd;
    d_req = v.dr; d_we = v.dw; d_lock = v.dl; d_addr = v.da; d_wdata = v.dd;
    #1;
    chk({nm, " p_gnt"}, p_gnt, v.epg);
    chk({nm, " d_gnt"}, d_gnt, v.edg);
    chk({nm, " p_stall"}, p_stall, v.pr & ~v.epg);
    if (v.epg) begin
      ea = v.pa[7:0];
      chk({nm, " mem_we"}, mem_we, v.pw);
      chk({nm, " mem_addr"}, mem_addr, ea);
      chk({nm, " mem_wd"}, mem_wd, v.pd);
      if (v.pw) exp_mem[ea] = v.pd;
      else      sb.push_back('{is_d: 1'b0, data: exp_mem[ea]});
    end else if (v.edg) begin
      ea = v.da[7:0];
      chk({nm, " mem_we"}, mem_we, v.dw);
      chk({nm, " mem_addr"}, mem_addr, ea);
      chk({nm, " mem_wd"}, mem_wd, v.dd);
      if (v.dw) exp_mem[ea] = v.dd;
      else      sb.push_back('{is_d: 1'b1, data: exp_mem[ea]});
    end else begin
      chk({nm, " idle mem_we"}, mem_we, 0);
      chk({nm, " idle mem_addr"}, mem_addr, 0);
      chk({nm, " idle mem_wd"}, mem_wd, 0);
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk({nm, " p_rvalid"}, p_rvalid, !it.is_d);
      chk({nm, " d_rvalid"}, d_rvalid, it.is_d);
      chk({nm, " rdata"}, rdata, it.data);
    end else begin
      chk({nm, " p_rvalid"}, p_rvalid, 0);
      chk({nm, " d_rvalid"}, d_rvalid, 0);
    end
  endtask

  vec_t tbl[10];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      exp_mem[i] = 32'hA500_0000 | i;
    end

    tbl[0] = mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0);
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 1, 0, 0, 32'h20, 0, 0, 1);
    tbl[3] = mk(1, 1, 32'h30, 32'h1234_5678, 0, 0, 0, 0, 0, 1, 0);
    tbl[4] = mk(0, 0, 0, 0, 1, 0, 0, 32'h30, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      tbl[5+i] = mk(1, 0, 32'h11 + i, 0, 1, 0, 0, 32'h21 + i, 0,
                    !RR || (i % 2 == 0), RR && (i % 2 == 1));
    tbl[9] = mk(1, 0, 32'h0000_1F13, 0, 0, 0, 0, 0, 0, 1, 0);

    // Reset held with both ports requesting.
    p_req = 1; d_req = 1; p_addr = 32'h55; d_addr = 32'h66; d_wdata = 32'h77; d_we = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset p_gnt", p_gnt, 0);
    chk("reset d_gnt", d_gnt, 0);
    chk("reset mem_we", mem_we, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wd", mem_wd, 0);
    chk("reset p_rvalid", p_rvalid, 0);
    chk("reset d_rvalid", d_rvalid, 0);
    rst = 1;

    for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Locked D write burst against a continuously waiting P read.
    for (int k = 1; k <= 20; k++)
      run_vec(mk(k > 1, 0, 32'h40, 0, 1, 1, 1, 32'h40, 32'hDEAD_BEEF,
                 (k == 17) || (!RR && k >= 18), (k <= 16) || (RR && k >= 18)),
              $sformatf("lock%0d", k));
    run_vec(mk(1, 0, 32'h40, 0, 1, 1, 0, 32'h42, 32'h0BAD_0BAD, 1, 0), "unlock");

    // Lock with no P pressure saturates; late P request is let in at once.
    for (int k = 1; k <= 20; k++)
      run_vec(mk(0, 0, 0, 0, 1, 1, 1, 32'h41, 32'hC0DE_0000 + k, 0, 1),
              $sformatf("sat%0d", k));
    run_vec(mk(1, 0, 32'h41, 0, 1, 1, 1, 32'h41, 32'hFFFF_FFFF, 1, 0), "sat_release");

    // Reset arrives in the middle of a D read grant.
    @(negedge clk);
    p_req = 0; p_we = 0; d_req = 1; d_we = 0; d_lock = 0; d_addr = 32'h20;
    #1;
    chk("midrst pre d_gnt", d_gnt, 1);
    #1;
    rst = 0;
    #1;
    chk("midrst d_gnt", d_gnt, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst mem_we", mem_we, 0);
    @(posedge clk);
    #1;
    chk("midrst d_rvalid", d_rvalid, 0);
    chk("midrst p_rvalid", p_rvalid, 0);
    chk("midrst rdata", rdata, 0);
    d_req = 0;
    rst = 1;
    run_vec(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
